// File: rtl/axi_apb_multi_bridge.sv
// AXI4-Lite to APB4 bridge fanning out to NUM_SLAVES 4 KiB windows, one transaction in flight.
// Optional APB_TIMEOUT_EN: abort an ACCESS phase after 256 cycles without pready (SLVERR).
module axi_apb_multi_bridge #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_SLAVES = 4
) (
  input  logic                           axi_aclk,
  input  logic                           axi_areset,
  input  logic [ADDR_WIDTH-1:0]          axi_awaddr,
  input  logic                           axi_awvalid,
  output logic                           axi_awready,
  input  logic [DATA_WIDTH-1:0]          axi_wdata,
  input  logic [DATA_WIDTH/8-1:0]        axi_wstrb,
  input  logic                           axi_wvalid,
  output logic                           axi_wready,
  output logic [1:0]                     axi_bresp,
  output logic                           axi_bvalid,
  input  logic                           axi_bready,
  input  logic [ADDR_WIDTH-1:0]          axi_araddr,
  input  logic                           axi_arvalid,
  output logic                           axi_arready,
  output logic [DATA_WIDTH-1:0]          axi_rdata,
  output logic [1:0]                     axi_rresp,
  output logic                           axi_rvalid,
  input  logic                           axi_rready,
  output logic [ADDR_WIDTH-1:0]          apb_paddr,
  output logic                           apb_pwrite,
  output logic [NUM_SLAVES-1:0]          apb_psel,
  output logic                           apb_penable,
  output logic [DATA_WIDTH-1:0]          apb_pwdata,
  output logic [DATA_WIDTH/8-1:0]        apb_pstrb,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] apb_prdata,
  input  logic [NUM_SLAVES-1:0]          apb_pready,
  input  logic [NUM_SLAVES-1:0]          apb_pslverr
);

  localparam int unsigned STRB_W = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(STRB_W - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETUP  = 2'd1;
  localparam logic [1:0] S_ACCESS = 2'd2;
  localparam logic [1:0] S_RESP   = 2'd3;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  logic [1:0]            state_q, state_d;
  logic                  wr_q, wr_d;
  logic                  last_wr_q, last_wr_d;
  logic [NUM_SLAVES-1:0] psel_q, psel_d;
  logic                  penable_q, penable_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic [STRB_W-1:0]     pstrb_q, pstrb_d;
  logic [1:0]            resp_q, resp_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  bvalid_q, bvalid_d;
  logic                  rvalid_q, rvalid_d;
`ifdef APB_TIMEOUT_EN
  logic [7:0]            tmo_q, tmo_d;
`endif

  logic                  wr_req, rd_req, grant_wr, grant_rd, idle;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [3:0]            req_idx;
  logic                  req_hit;
  logic [NUM_SLAVES-1:0] sel_dec;
  logic                  sel_ready, sel_err;
  logic [DATA_WIDTH-1:0] sel_rdata;
  logic                  done;
  logic [1:0]            done_resp;
  logic [DATA_WIDTH-1:0] done_rdata;

  // Round-robin between directions: on a tie, whichever was not served last wins.
  assign wr_req   = axi_awvalid & axi_wvalid;
  assign rd_req   = axi_arvalid;
  assign grant_wr = wr_req & (~rd_req | ~last_wr_q);
  assign grant_rd = rd_req & ~grant_wr;
  assign idle     = (state_q == S_IDLE) & ~axi_areset;

  assign axi_awready = idle & grant_wr;
  assign axi_wready  = idle & grant_wr;
  assign axi_arready = idle & grant_rd;

  assign req_addr = grant_wr ? axi_awaddr : axi_araddr;
  assign req_idx  = req_addr[15:12];
  assign req_hit  = ({1'b0, req_idx} < 5'(NUM_SLAVES));

  always_comb begin
    sel_dec = '0;
    for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
      sel_dec[i] = (req_idx == 4'(i));
    end
  end

  always_comb begin
    sel_ready = 1'b0;
    sel_err   = 1'b0;
    sel_rdata = '0;
    for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
      if (psel_q[i]) begin
        sel_ready = apb_pready[i];
        sel_err   = apb_pslverr[i];
        sel_rdata = apb_prdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    wr_d      = wr_q;
    last_wr_d = last_wr_q;
    psel_d    = psel_q;
    penable_d = penable_q;
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;
    pstrb_d   = pstrb_q;
    resp_d    = resp_q;
    rdata_d   = rdata_q;
    bvalid_d  = bvalid_q;
    rvalid_d  = rvalid_q;
`ifdef APB_TIMEOUT_EN
    tmo_d     = tmo_q;
`endif
    done       = 1'b0;
    done_resp  = RESP_OKAY;
    done_rdata = '0;

    case (state_q)
      S_IDLE: begin
        if (grant_wr | grant_rd) begin
          wr_d      = grant_wr;
          last_wr_d = grant_wr;
          if (req_hit) begin
            psel_d   = sel_dec;
            paddr_d  = req_addr & ALIGN_MASK;
            pwdata_d = grant_wr ? axi_wdata : '0;
            pstrb_d  = grant_wr ? axi_wstrb : '0;
            state_d  = S_SETUP;
          end else begin
            resp_d   = RESP_DECERR;
            rdata_d  = '0;
            bvalid_d = grant_wr;
            rvalid_d = ~grant_wr;
            state_d  = S_RESP;
          end
        end
      end
      S_SETUP: begin
        penable_d = 1'b1;
`ifdef APB_TIMEOUT_EN
        tmo_d     = '0;
`endif
        state_d   = S_ACCESS;
      end
      S_ACCESS: begin
        if (sel_ready) begin
          done       = 1'b1;
          done_resp  = sel_err ? RESP_SLVERR : RESP_OKAY;
          done_rdata = wr_q ? '0 : sel_rdata;
        end
`ifdef APB_TIMEOUT_EN
        // Counter holds completed waiting cycles; the 256th unanswered cycle aborts.
        else if (tmo_q == 8'hFF) begin
          done       = 1'b1;
          done_resp  = RESP_SLVERR;
          done_rdata = '0;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
`endif
        if (done) begin
          psel_d    = '0;
          penable_d = 1'b0;
          resp_d    = done_resp;
          rdata_d   = done_rdata;
          bvalid_d  = wr_q;
          rvalid_d  = ~wr_q;
          state_d   = S_RESP;
        end
      end
      default: begin
        if ((bvalid_q & axi_bready) | (rvalid_q & axi_rready)) begin
          bvalid_d = 1'b0;
          rvalid_d = 1'b0;
          state_d  = S_IDLE;
        end
      end
    endcase
  end

  // last_wr_q resets high so the first tie goes to the read channel.
  always_ff @(posedge axi_aclk) begin
    if (axi_areset) begin
      state_q   <= S_IDLE;
      wr_q      <= 1'b0;
      last_wr_q <= 1'b1;
      psel_q    <= '0;
      penable_q <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      pstrb_q   <= '0;
      resp_q    <= '0;
      rdata_q   <= '0;
      bvalid_q  <= 1'b0;
      rvalid_q  <= 1'b0;
`ifdef APB_TIMEOUT_EN
      tmo_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      wr_q      <= wr_d;
      last_wr_q <= last_wr_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
      pstrb_q   <= pstrb_d;
      resp_q    <= resp_d;
      rdata_q   <= rdata_d;
      bvalid_q  <= bvalid_d;
      rvalid_q  <= rvalid_d;
`ifdef APB_TIMEOUT_EN
      tmo_q     <= tmo_d;
`endif
    end
  end

  assign apb_paddr   = paddr_q;
  assign apb_pwrite  = wr_q;
  assign apb_psel    = psel_q;
  assign apb_penable = penable_q;
  assign apb_pwdata  = pwdata_q;
  assign apb_pstrb   = pstrb_q;
  assign axi_bresp   = resp_q;
  assign axi_bvalid  = bvalid_q;
  assign axi_rresp   = resp_q;
  assign axi_rdata   = rdata_q;
  assign axi_rvalid  = rvalid_q;

endmodule

// File: doc/axi_apb_multi_bridge.md
AXI_APB_MULTI_BRIDGE -- requirements
Module: axi_apb_multi_bridge

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, AXI/APB address width (minimum 16).
REQ-002 SHALL have parameter DATA_WIDTH, default 32, AXI/APB data width (32 or 64).
REQ-003 SHALL have parameter NUM_SLAVES, default 4, number of APB slaves (1..16); slave i owns the 4 KiB window i*0x1000.
REQ-004 SHALL have one clock and a synchronous, active-high reset: axi_aclk clocks all logic; axi_areset is the synchronous active-high reset.
REQ-005 axi_aclk  in  1  clock.
REQ-006 axi_areset  in  1  synchronous active-high reset.
REQ-007 axi_awaddr  in  ADDR_WIDTH  write address.
REQ-008 axi_awvalid  in  1  write address valid.
REQ-009 axi_awready  out  1  write address accepted.
REQ-010 axi_wdata  in  DATA_WIDTH  write data.
REQ-011 axi_wstrb  in  DATA_WIDTH/8  write byte strobes.
REQ-012 axi_wvalid  in  1  write data valid.
REQ-013 axi_wready  out  1  write data accepted.
REQ-014 axi_bresp  out  2  write response.
REQ-015 axi_bvalid  out  1  write response valid.
REQ-016 axi_bready  in  1  write response ready.
REQ-017 axi_araddr  in  ADDR_WIDTH  read address.
REQ-018 axi_arvalid  in  1  read address valid.
REQ-019 axi_arready  out  1  read address accepted.
REQ-020 axi_rdata  out  DATA_WIDTH  read data.
REQ-021 axi_rresp  out  2  read response.
REQ-022 axi_rvalid  out  1  read data valid.
REQ-023 axi_rready  in  1  read data ready.
REQ-024 apb_paddr  out  ADDR_WIDTH  APB address, word-aligned (low log2(DATA_WIDTH/8) bits zero).
REQ-025 apb_pwrite  out  1  APB direction, 1 = write.
REQ-026 apb_psel  out  NUM_SLAVES  one-hot slave select.
REQ-027 apb_penable  out  1  APB access phase.
REQ-028 apb_pwdata  out  DATA_WIDTH  APB write data.
REQ-029 apb_pstrb  out  DATA_WIDTH/8  APB4 strobes; axi_wstrb on writes, all-zero on reads.
REQ-030 apb_prdata  in  NUM_SLAVES*DATA_WIDTH  per-slave read data, slave i at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-031 apb_pready  in  NUM_SLAVES  per-slave ready.
REQ-032 apb_pslverr  in  NUM_SLAVES  per-slave error.

Function
REQ-033 FSM SHALL have states IDLE, SETUP, ACCESS, RESP; one transaction outstanding at a time.
REQ-034 In IDLE, a write SHALL be accepted only when axi_awvalid and axi_wvalid are both high; axi_awready and axi_wready SHALL pulse together for exactly that one cycle; a read is accepted by a one-cycle axi_arready pulse.
REQ-035 Write and read both pending in IDLE SHALL be arbitrated round-robin: the direction not served last wins; after reset, read wins first.
REQ-036 Slave index = addr[15:12]; index < NUM_SLAVES -> SETUP next cycle with the decoded psel bit high and penable low; ACCESS follows one cycle later with penable high.
REQ-037 In ACCESS, the bridge SHALL hold all APB outputs stable until the selected apb_pready is high; on that cycle it SHALL capture prdata/pslverr, drop psel and penable, and enter RESP.
REQ-038 Index >= NUM_SLAVES SHALL issue no APB access (psel stays zero) and go from IDLE directly to RESP with resp 2'b11 (DECERR) and rdata 0.
REQ-039 Response codes: OKAY 2'b00, pslverr high -> SLVERR 2'b10; rdata is driven with the captured prdata on SLVERR as well.
REQ-040 In RESP, bvalid or rvalid with its data/resp SHALL be held stable until bready/rready is high; the handshake cycle returns the FSM to IDLE; no new address is accepted before IDLE.
REQ-041 Minimum latency for a decoded access with pready already high: accept at cycle N, SETUP N+1, ACCESS N+2, valid response at N+3.

Reset
REQ-042 While axi_areset is high, including mid-transaction, the FSM SHALL enter IDLE and all ready/valid/psel/penable outputs, resp, rdata, paddr, pwdata and pstrb SHALL be 0 on the next edge; the pending transfer is dropped.

Configuration
REQ-043 With APB_TIMEOUT_EN defined, the bridge SHALL count ACCESS cycles; if pready is still low after 256 cycles, it SHALL abort the access (drop psel/penable) and respond SLVERR with rdata 0.
REQ-044 Without APB_TIMEOUT_EN, ACCESS SHALL wait for pready indefinitely and the bridge SHALL contain no counter logic.

Verification
REQ-045 Write 0x0000_1008 data 0xDEADBEEF wstrb 0xF with pready[1]=1 -> psel=4'b0010, paddr 0x1008, pstrb 0xF, bresp 00 at accept+3.
REQ-046 Read 0x0000_2004 with slave 2 returning 0x12345678 after 3 wait states -> rdata 0x12345678, rresp 00; penable held high for 4 cycles.
REQ-047 Write 0x0000_0000 with pslverr[0]=1 -> bresp 10; read 0x0000_5000 with NUM_SLAVES=4 -> psel never set, rresp 11, rdata 0.
REQ-048 AW+W and AR asserted together for two back-to-back transactions after reset -> read served first, then write; bvalid held 5 cycles while bready low.
REQ-049 Assert axi_areset while in ACCESS -> all outputs 0 next cycle; with APB_TIMEOUT_EN and pready stuck low -> SLVERR after 256 ACCESS cycles.
